stk_mem_xfer: RTL and testbench
===============================

Name: stk_mem_xfer

Overview:
Parametrised stack/memory transfer unit for the stack-machine datapath. Accepts one command at a time over a valid/ready handshake and moves a word between the operand stack and data memory. Supported transfers: constant to stack, memory to stack, stack to memory, plus indirect forms that take the address from the stack top. Sits between the decoder/control bus and the stack and data-memory blocks. It replaces tri-stated idle outputs with defined 0 levels, and adds configurable memory read latency and stack full/empty error reporting.

Parameters:
ADDR_LEN, 8, memory address width
DATA_LEN, 8, data word width (stack and memory)
MEM_RD_LAT, 1, cycles from mem_r_en sample to mem_data_out valid; legal values are 1 or greater

Ports:
clk  in  1  clock, rising edge
rstn  in  1  asynchronous active-low reset
en  in  1  unit enable; gates command acceptance only
cmd_valid  in  1  command present
cmd_ready  out  1  unit can accept a command
cmd_op  in  3  000 NOP, 001 PUSH_C, 010 LOAD, 011 STORE, 100 LOAD_IND, 101 STORE_IND, 110/111 illegal
cmd_addr  in  ADDR_LEN  direct address, or offset for the indirect forms
cmd_const  in  DATA_LEN  constant for PUSH_C
done  out  1  one-cycle pulse when a command completes
err  out  1  last command failed; valid with done and held until the next accept
err_code  out  2  00 none, 01 overflow, 10 underflow, 11 illegal op
stk_push  out  1  one-cycle push strobe
stk_pop  out  1  one-cycle pop strobe
stk_data_in  out  DATA_LEN  push data
stk_data_out  in  DATA_LEN  stack top; valid the cycle after a pop strobe, stable until the next pop
stk_full  in  1  stack full
stk_empty  in  1  stack empty
mem_r_en  out  1  memory read strobe
mem_w_en  out  1  memory write strobe
mem_addr  out  ADDR_LEN  memory address
mem_data_in  out  DATA_LEN  memory write data
mem_data_out  in  DATA_LEN  memory read data

Behaviour:
- Clock and reset: one clock, clk. Reset is rstn, asynchronous and active-low.
- Reset values: every output is 0 and state is IDLE. Reset asserted mid-command drops all strobes immediately, aborts the command, and does not pulse done.
- States: IDLE, POP_A, ADDR, READ, WAIT, PUSH, POP_D, WRITE, DONE.
- IDLE:
  - cmd_ready = en.
  - A command is accepted on an edge where cmd_valid, cmd_ready and en are all 1. On accept, op, addr and const are latched and err/err_code are cleared.
- Next state after accept, by op:
  - NOP: DONE.
  - PUSH_C: PUSH.
  - LOAD: READ, with ea = cmd_addr.
  - STORE: POP_D.
  - LOAD_IND, STORE_IND: POP_A.
  - Illegal op: DONE with err_code 11.
- cmd_ready is 0 in every state other than IDLE.
- POP_A:
  - If stk_empty: no strobe, go to DONE with err_code 10.
  - Otherwise stk_pop = 1, go to ADDR.
- ADDR:
  - Captures ea = zero-extended stk_data_out[min(ADDR_LEN,DATA_LEN)-1:0] + cmd_addr, modulo 2^ADDR_LEN (wraps, no error).
  - LOAD_IND goes to READ.
  - STORE_IND checks stk_empty in the same cycle. If empty, go to DONE with err_code 10. Otherwise stk_pop = 1 and go to WRITE.
- POP_D (STORE):
  - If stk_empty: DONE with err_code 10.
  - Otherwise stk_pop = 1, go to WRITE.
- READ:
  - mem_r_en = 1, mem_addr = ea, go to WAIT.
- WAIT:
  - Stays MEM_RD_LAT cycles.
  - Captures mem_data_out into the data register at the edge ending the last WAIT cycle, then goes to PUSH.
- PUSH:
  - If stk_full: no strobe, go to DONE with err_code 01. For LOAD the memory read has already occurred.
  - Otherwise stk_push = 1 and stk_data_in = the const (PUSH_C) or the data register (loads); go to DONE.
- WRITE:
  - mem_w_en = 1, mem_addr = ea (cmd_addr for STORE), mem_data_in = stk_data_out; go to DONE.
- DONE:
  - done = 1 and err reflects err_code != 0; go to IDLE.
- Strobe rules:
  - mem_r_en and mem_w_en are never both 1.
  - Each strobe is high for exactly one cycle per command.
  - Data and address outputs are 0 whenever their strobe is 0.
- en deasserted mid-command does not abort the command; it only blocks the next accept.
- Latency (accept edge to done cycle, inclusive count of cycles after accept), L = MEM_RD_LAT:
  - NOP / illegal: 1
  - PUSH_C: 2
  - STORE: 3
  - STORE_IND: 4
  - LOAD: 3 + L
  - LOAD_IND: 5 + L
- Back-to-back: the next command can be accepted in the IDLE cycle right after DONE.

Test Plan:
- PUSH_C const=0x5A, stk_full=0: stk_push in cycle 1 with stk_data_in=0x5A, done in cycle 2, err=0, cmd_ready=1 in cycle 3.
- LOAD addr=0x10, mem[0x10]=0xC3, MEM_RD_LAT=2: mem_r_en with mem_addr=0x10 in cycle 1, stk_push with 0xC3 in cycle 4, done in cycle 5.
- STORE_IND cmd_addr=0x02, stack top to bottom = 0xFF (address), 0x77 (data): ea=0x01 (wraps), mem_w_en with mem_addr=0x01 and mem_data_in=0x77, two stk_pop pulses, done in cycle 4.
- STORE with stk_empty=1: no stk_pop, no mem_w_en, done in cycle 2 with err=1, err_code=10. PUSH_C with stk_full=1: no stk_push, err_code=01.
- cmd_op=111: done in cycle 1, err_code=11. en=0 with cmd_valid=1: cmd_ready=0 and no accept until en returns to 1.
- rstn pulled low during WAIT of a LOAD: all outputs 0 immediately, no done and no push. After release, a PUSH_C completes normally.

Source files
------------

// File: rtl/stk_mem_xfer.sv
// Stack/memory transfer unit: moves one word per command between the
// operand stack and data memory over a valid/ready command handshake.
// Ports:
//   clk, rstn                      clock, async active-low reset
//   en                             gates command acceptance
//   cmd_valid/cmd_ready            command handshake
//   cmd_op/cmd_addr/cmd_const      command fields
//   done, err, err_code            completion pulse and status
//   stk_push/pop, stk_data_in/out  stack side, stk_full/stk_empty flags
//   mem_r_en/w_en, mem_addr        memory strobes and address
//   mem_data_in/out                memory write and read data
module stk_mem_xfer #(
    parameter int ADDR_LEN   = 8,
    parameter int DATA_LEN   = 8,
    parameter int MEM_RD_LAT = 1
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                en,
    input  logic                cmd_valid,
    output logic                cmd_ready,
    input  logic [2:0]          cmd_op,
    input  logic [ADDR_LEN-1:0] cmd_addr,
    input  logic [DATA_LEN-1:0] cmd_const,
    output logic                done,
    output logic                err,
    output logic [1:0]          err_code,
    output logic                stk_push,
    output logic                stk_pop,
    output logic [DATA_LEN-1:0] stk_data_in,
    input  logic [DATA_LEN-1:0] stk_data_out,
    input  logic                stk_full,
    input  logic                stk_empty,
    output logic                mem_r_en,
    output logic                mem_w_en,
    output logic [ADDR_LEN-1:0] mem_addr,
    output logic [DATA_LEN-1:0] mem_data_in,
    input  logic [DATA_LEN-1:0] mem_data_out
);

    localparam int AW = (ADDR_LEN < DATA_LEN) ? ADDR_LEN : DATA_LEN;
    localparam int CW = (MEM_RD_LAT > 1) ? $clog2(MEM_RD_LAT) : 1;

    localparam logic [2:0] OP_NOP   = 3'b000;
    localparam logic [2:0] OP_PUSHC = 3'b001;
    localparam logic [2:0] OP_LOAD  = 3'b010;
    localparam logic [2:0] OP_STORE = 3'b011;
    localparam logic [2:0] OP_LDI   = 3'b100;
    localparam logic [2:0] OP_STI   = 3'b101;

    typedef enum logic [3:0] {
        S_IDLE, S_POP_A, S_ADDR, S_READ, S_WAIT,
        S_PUSH, S_POP_D, S_WRITE, S_DONE
    } state_t;

    state_t              state, state_d;
    logic [2:0]          op_q;
    logic [ADDR_LEN-1:0] addr_q, ea_q, top_ext;
    logic [DATA_LEN-1:0] const_q, data_q;
    logic [CW-1:0]       cnt_q;
    logic [1:0]          code_q, code_d;
    logic                accept, wait_last;

    assign accept    = (state == S_IDLE) && cmd_valid && en;
    assign wait_last = (cnt_q == CW'(MEM_RD_LAT - 1));

    // Low bits of the popped stack word, zero-extended to address width.
    always_comb begin
        top_ext = '0;
        top_ext[AW-1:0] = stk_data_out[AW-1:0];
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_d;
    end

    always_comb begin
        state_d = state;
        code_d  = code_q;
        unique case (state)
            S_IDLE: begin
                if (accept) begin
                    code_d = 2'b00;
                    unique case (cmd_op)
                        OP_NOP:   state_d = S_DONE;
                        OP_PUSHC: state_d = S_PUSH;
                        OP_LOAD:  state_d = S_READ;
                        OP_STORE: state_d = S_POP_D;
                        OP_LDI,
                        OP_STI:   state_d = S_POP_A;
                        default: begin
                            state_d = S_DONE;
                            code_d  = 2'b11;
                        end
                    endcase
                end
            end
            S_POP_A, S_POP_D: begin
                if (stk_empty) begin
                    state_d = S_DONE;
                    code_d  = 2'b10;
                end else begin
                    state_d = (state == S_POP_A) ? S_ADDR : S_WRITE;
                end
            end
            S_ADDR: begin
                if (op_q == OP_LDI) begin
                    state_d = S_READ;
                end else if (stk_empty) begin
                    state_d = S_DONE;
                    code_d  = 2'b10;
                end else begin
                    state_d = S_WRITE;
                end
            end
            S_READ:  state_d = S_WAIT;
            S_WAIT:  if (wait_last) state_d = S_PUSH;
            S_PUSH: begin
                state_d = S_DONE;
                if (stk_full) code_d = 2'b01;
            end
            S_WRITE: state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            op_q    <= '0;
            addr_q  <= '0;
            const_q <= '0;
            ea_q    <= '0;
            data_q  <= '0;
            cnt_q   <= '0;
            code_q  <= '0;
        end else begin
            code_q <= code_d;
            if (accept) begin
                op_q    <= cmd_op;
                addr_q  <= cmd_addr;
                const_q <= cmd_const;
                ea_q    <= cmd_addr;
            end
            if (state == S_ADDR) ea_q <= top_ext + addr_q;
            if (state == S_READ) cnt_q <= '0;
            if (state == S_WAIT) begin
                cnt_q <= cnt_q + 1'b1;
                if (wait_last) data_q <= mem_data_out;
            end
        end
    end

    always_comb begin
        // rstn gating keeps cmd_ready low while reset is held in IDLE.
        cmd_ready   = rstn && (state == S_IDLE) && en;
        done        = (state == S_DONE);
        err         = |code_q;
        err_code    = code_q;
        stk_pop     = 1'b0;
        stk_push    = 1'b0;
        stk_data_in = '0;
        mem_r_en    = 1'b0;
        mem_w_en    = 1'b0;
        mem_addr    = '0;
        mem_data_in = '0;
        unique case (state)
            S_POP_A, S_POP_D: stk_pop = !stk_empty;
            S_ADDR:  stk_pop = (op_q == OP_STI) && !stk_empty;
            S_READ: begin
                mem_r_en = 1'b1;
                mem_addr = ea_q;
            end
            S_PUSH: begin
                stk_push = !stk_full;
                if (!stk_full)
                    stk_data_in = (op_q == OP_PUSHC) ? const_q : data_q;
            end
            S_WRITE: begin
                mem_w_en    = 1'b1;
                mem_addr    = ea_q;
                mem_data_in = stk_data_out;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_stk_mem_xfer.sv
// Testbench for stk_mem_xfer: stack and memory environment models plus a
// queue-based reference of each command's effect, latency and status.
module tb_stk_mem_xfer;

    localparam int AL    = 8;
    localparam int DL    = 8;
    localparam int LAT   = 2;
    localparam int DEPTH = 4;

    logic          clk, rstn, en, cmd_valid, cmd_ready;
    logic [2:0]    cmd_op;
    logic [AL-1:0] cmd_addr, mem_addr;
    logic [DL-1:0] cmd_const, stk_data_in, stk_data_out;
    logic [DL-1:0] mem_data_in, mem_data_out;
    logic          done, err, stk_push, stk_pop, stk_full, stk_empty;
    logic [1:0]    err_code;
    logic          mem_r_en, mem_w_en;
    logic          env_clr;

    int checks = 0;
    int errors = 0;

    stk_mem_xfer #(.ADDR_LEN(AL), .DATA_LEN(DL), .MEM_RD_LAT(LAT)) dut (
        .clk(clk), .rstn(rstn), .en(en),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_const(cmd_const),
        .done(done), .err(err), .err_code(err_code),
        .stk_push(stk_push), .stk_pop(stk_pop),
        .stk_data_in(stk_data_in), .stk_data_out(stk_data_out),
        .stk_full(stk_full), .stk_empty(stk_empty),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .mem_addr(mem_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stack environment
    logic [DL-1:0] stk [DEPTH];
    int            sp;
    logic [DL-1:0] stk_q;
    always @(posedge clk) begin
        if (env_clr) begin
            sp    <= 0;
            stk_q <= '0;
        end else begin
            if (stk_push && sp < DEPTH) begin
                stk[sp] <= stk_data_in;
                sp      <= sp + 1;
            end
            if (stk_pop && sp > 0) begin
                stk_q <= stk[sp-1];
                sp    <= sp - 1;
            end
        end
    end
    assign stk_data_out = stk_q;
    assign stk_full     = (sp == DEPTH);
    assign stk_empty    = (sp == 0);

    // Memory environment with LAT-cycle read pipeline, noise when idle
    logic [DL-1:0] mem [256];
    logic          pv [LAT];
    logic [DL-1:0] pd [LAT];
    logic [DL-1:0] noise;
    always @(posedge clk) begin
        noise <= DL'($urandom);
        if (env_clr) begin
            for (int i = 0; i < 256; i++) mem[i] <= DL'(i * 37 + 11);
        end else if (mem_w_en) begin
            mem[mem_addr] <= mem_data_in;
        end
        pv[0] <= mem_r_en;
        pd[0] <= mem[mem_addr];
        for (int i = 1; i < LAT; i++) begin
            pv[i] <= pv[i-1];
            pd[i] <= pd[i-1];
        end
    end
    assign mem_data_out = pv[LAT-1] ? pd[LAT-1] : noise;

    // Reference state
    logic [DL-1:0] rmem [256];
    logic [DL-1:0] rstk [$];

    // Expected results of the current command
    int            e_lat, e_code, e_pu, e_po, e_rd, e_wr;
    logic [DL-1:0] e_pdat, e_wdat;
    logic [AL-1:0] e_raddr, e_waddr;

    // Observed results of the current command
    int            o_lat, o_code, o_err, o_pu, o_po, o_rd, o_wr;
    int            push_cyc, rd_cyc, wr_cyc;
    logic [DL-1:0] push_dat, wr_dat;
    logic [AL-1:0] rd_addr, wr_addr;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic ref_cmd(input logic [2:0] op, input logic [AL-1:0] a,
                           input logic [DL-1:0] c);
        logic [DL-1:0] v, d;
        logic [AL-1:0] ea;
        e_lat = 1; e_code = 0; e_pu = 0; e_po = 0; e_rd = 0; e_wr = 0;
        e_pdat = '0; e_wdat = '0; e_raddr = '0; e_waddr = '0;
        case (op)
            3'd0: e_lat = 1;
            3'd1: begin
                e_lat = 2;
                if (rstk.size() == DEPTH) e_code = 1;
                else begin e_pu = 1; e_pdat = c; rstk.push_front(c); end
            end
            3'd2: begin
                e_lat = 3 + LAT; e_rd = 1; e_raddr = a;
                if (rstk.size() == DEPTH) e_code = 1;
                else begin
                    e_pu = 1; e_pdat = rmem[a]; rstk.push_front(rmem[a]);
                end
            end
            3'd3: begin
                if (rstk.size() == 0) begin e_lat = 2; e_code = 2; end
                else begin
                    e_lat = 3; e_po = 1; d = rstk.pop_front();
                    e_wr = 1; e_waddr = a; e_wdat = d; rmem[a] = d;
                end
            end
            3'd4: begin
                if (rstk.size() == 0) begin e_lat = 2; e_code = 2; end
                else begin
                    e_po = 1; v = rstk.pop_front();
                    ea = AL'((int'(v) + int'(a)) % 256);
                    e_lat = 5 + LAT; e_rd = 1; e_raddr = ea;
                    e_pu = 1; e_pdat = rmem[ea]; rstk.push_front(rmem[ea]);
                end
            end
            3'd5: begin
                if (rstk.size() == 0) begin e_lat = 2; e_code = 2; end
                else begin
                    e_po = 1; v = rstk.pop_front();
                    ea = AL'((int'(v) + int'(a)) % 256);
                    if (rstk.size() == 0) begin e_lat = 3; e_code = 2; end
                    else begin
                        e_po = 2; d = rstk.pop_front(); e_lat = 4;
                        e_wr = 1; e_waddr = ea; e_wdat = d; rmem[ea] = d;
                    end
                end
            end
            default: begin e_lat = 1; e_code = 3; end
        endcase
    endtask

    task automatic run_cmd(input logic [2:0] op, input logic [AL-1:0] a,
                           input logic [DL-1:0] c);
        bit got;
        o_lat = 0; o_code = 0; o_err = 0; o_pu = 0; o_po = 0;
        o_rd = 0; o_wr = 0; push_cyc = 0; rd_cyc = 0; wr_cyc = 0;
        push_dat = '0; wr_dat = '0; rd_addr = '0; wr_addr = '0;
        got = 0;
        @(negedge clk);
        en = 1'b1; cmd_valid = 1'b1;
        cmd_op = op; cmd_addr = a; cmd_const = c;
        #1 chk("ready_pre", 32'(cmd_ready), 1);
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        for (int cyc = 1; cyc <= 40 && !got; cyc++) begin
            @(negedge clk);
            chk("busy_ready", 32'(cmd_ready), 0);
            chk("rw_excl", 32'(mem_r_en & mem_w_en), 0);
            chk("push_dat_idle0", 32'(!stk_push && stk_data_in != 0), 0);
            chk("addr_idle0", 32'(!mem_r_en && !mem_w_en && mem_addr != 0), 0);
            chk("wdat_idle0", 32'(!mem_w_en && mem_data_in != 0), 0);
            if (stk_push) begin o_pu++; push_cyc = cyc; push_dat = stk_data_in; end
            if (stk_pop) o_po++;
            if (mem_r_en) begin o_rd++; rd_cyc = cyc; rd_addr = mem_addr; end
            if (mem_w_en) begin
                o_wr++; wr_cyc = cyc; wr_addr = mem_addr; wr_dat = mem_data_in;
            end
            if (done) begin
                got = 1; o_lat = cyc; o_code = int'(err_code); o_err = int'(err);
            end
        end
        if (!got) chk("done_timeout", 0, 1);
        @(negedge clk);
        chk("ready_post", 32'(cmd_ready), 1);
        chk("err_held", 32'(err), 32'(e_code != 0));
        chk("done_pulse", 32'(done), 0);
    endtask

    task automatic compare(input string n);
        chk({n, "_lat"}, 32'(o_lat), 32'(e_lat));
        chk({n, "_code"}, 32'(o_code), 32'(e_code));
        chk({n, "_err"}, 32'(o_err), 32'(e_code != 0));
        chk({n, "_pushes"}, 32'(o_pu), 32'(e_pu));
        chk({n, "_pops"}, 32'(o_po), 32'(e_po));
        chk({n, "_reads"}, 32'(o_rd), 32'(e_rd));
        chk({n, "_writes"}, 32'(o_wr), 32'(e_wr));
        if (e_pu != 0) chk({n, "_push_dat"}, 32'(push_dat), 32'(e_pdat));
        if (e_rd != 0) chk({n, "_rd_addr"}, 32'(rd_addr), 32'(e_raddr));
        if (e_wr != 0) begin
            chk({n, "_wr_addr"}, 32'(wr_addr), 32'(e_waddr));
            chk({n, "_wr_dat"}, 32'(wr_dat), 32'(e_wdat));
            chk({n, "_mem"}, 32'(mem[e_waddr]), 32'(rmem[e_waddr]));
        end
        chk({n, "_depth"}, 32'(sp), 32'(rstk.size()));
        if (rstk.size() > 0 && sp > 0)
            chk({n, "_top"}, 32'(stk[sp-1]), 32'(rstk[0]));
    endtask

    task automatic do_cmd(input string n, input logic [2:0] op,
                          input logic [AL-1:0] a, input logic [DL-1:0] c);
        ref_cmd(op, a, c);
        run_cmd(op, a, c);
        compare(n);
    endtask

    initial begin
        int sp_save;
        rstn = 1'b0; env_clr = 1'b1; en = 1'b1; cmd_valid = 1'b0;
        cmd_op = '0; cmd_addr = '0; cmd_const = '0;
        for (int i = 0; i < 256; i++) rmem[i] = DL'(i * 37 + 11);
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", {29'd0, err, err_code}, 0);
        chk("rst_strobes", {28'd0, stk_push, stk_pop, mem_r_en, mem_w_en}, 0);
        chk("rst_buses", {8'd0, mem_addr, mem_data_in, stk_data_in}, 0);
        rstn = 1'b1; env_clr = 1'b0;
        #1 chk("ready_after_rst", 32'(cmd_ready), 1);

        do_cmd("store_empty", 3'd3, 8'h20, 8'h00);

        do_cmd("pushc", 3'd1, 8'h00, 8'h5A);
        chk("pushc_cyc", 32'(push_cyc), 1);

        do_cmd("pushc2", 3'd1, 8'h00, 8'hC3);
        do_cmd("store", 3'd3, 8'h10, 8'h00);
        chk("store_wr_cyc", 32'(wr_cyc), 2);
        do_cmd("load", 3'd2, 8'h10, 8'h00);
        chk("load_rd_cyc", 32'(rd_cyc), 1);
        chk("load_push_cyc", 32'(push_cyc), 4);
        chk("load_push_c3", 32'(push_dat), 32'h C3);

        do_cmd("pushc3", 3'd1, 8'h00, 8'h77);
        do_cmd("pushc4", 3'd1, 8'h00, 8'hFF);
        do_cmd("pushc_full", 3'd1, 8'h00, 8'h11);
        do_cmd("sti", 3'd5, 8'h02, 8'h00);
        chk("sti_wr_addr", 32'(wr_addr), 32'h01);
        chk("sti_wr_dat", 32'(wr_dat), 32'h77);
        chk("sti_wr_cyc", 32'(wr_cyc), 3);

        do_cmd("illegal", 3'd7, 8'h00, 8'h00);

        @(negedge clk);
        en = 1'b0; cmd_valid = 1'b1; cmd_op = 3'd1; cmd_const = 8'h33;
        sp_save = sp;
        repeat (3) begin
            @(negedge clk);
            chk("en0_ready", 32'(cmd_ready), 0);
            chk("en0_busy", {30'd0, done, stk_push}, 0);
        end
        chk("en0_depth", 32'(sp), 32'(sp_save));
        do_cmd("en_back", 3'd1, 8'h00, 8'h33);

        @(negedge clk);
        cmd_valid = 1'b1; cmd_op = 3'd2; cmd_addr = 8'h40;
        @(posedge clk);
        #1 cmd_valid = 1'b0;
        sp_save = sp;
        @(negedge clk);
        chk("abort_rd", 32'(mem_r_en), 1);
        @(negedge clk);
        #1 rstn = 1'b0;
        #1;
        chk("abort_strobes", {28'd0, stk_push, stk_pop, mem_r_en, mem_w_en}, 0);
        chk("abort_outs", {29'd0, done, cmd_ready, err}, 0);
        chk("abort_addr", 32'(mem_addr), 0);
        repeat (2) begin
            @(negedge clk);
            chk("abort_nodone", {30'd0, done, stk_push}, 0);
        end
        rstn = 1'b1;
        chk("abort_depth", 32'(sp), 32'(sp_save));
        do_cmd("after_rst", 3'd1, 8'h00, 8'h99);

        for (int k = 0; k < 60; k++) begin
            do_cmd("rand", 3'($urandom_range(0, 7)),
                   AL'($urandom), DL'($urandom));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
